// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and helpers for the fetch-side branch predictor.
package y86_pkg;

    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;
    localparam logic [3:0] IFUN_JMP   = 4'h0;
    localparam logic [1:0] CTR_WT     = 2'b10;

    // Where the predicted next PC comes from.
    typedef enum logic [1:0] {
        PRED_SEQ,
        PRED_TARGET,
        PRED_RAS
    } pred_src_e;

    // 2-bit saturating counter step: 3 and 0 stick.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/y86_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry, pop on empty is ignored.
module y86_ras #(
    parameter int AW    = 64,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_data,
    output logic [AW-1:0] o_top,
    output logic [CW-1:0] o_count
);

    logic [AW-1:0] r_stack [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;

    assign o_top   = r_stack[r_ptr - PW'(1)];
    assign o_count = r_count;

    // NOTE: the storage array has no reset; r_count guards every read, so
    // stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_stack[r_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PW'(1);
            if (r_count != CW'(DEPTH)) begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop && r_count != '0) begin
            r_ptr   <= r_ptr - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/y86_branch_predictor.sv
// Next-PC predictor beside fetch: bimodal/gshare PHT for jXX, RAS for ret, with perf counters.
module y86_branch_predictor
    import y86_pkg::*;
#(
    parameter int AW        = 64,
    parameter int PHT_BITS  = 6,
    parameter int MODE      = 0,
    parameter int HIST_BITS = 6,
    parameter int RAS_DEPTH = 8,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    input  logic             f_stall,
    input  logic [AW-1:0]    f_pc,
    input  logic [3:0]       f_icode,
    input  logic [3:0]       f_ifun,
    input  logic [AW-1:0]    f_valC,
    input  logic [AW-1:0]    f_valP,
    output logic [AW-1:0]    pred_pc,
    output logic             pred_taken,
    output logic             ras_miss,
    input  logic             e_valid,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [AW-1:0]    e_pc,
    input  logic [AW-1:0]    e_valC,
    input  logic [AW-1:0]    e_valP,
    input  logic             e_Cnd,
    input  logic             e_pred_taken,
    output logic             e_mispredict,
    output logic [AW-1:0]    e_redirect_pc,
    input  logic             m_ret_valid,
    input  logic [AW-1:0]    m_ret_pred,
    input  logic [AW-1:0]    m_valM,
    output logic             m_ret_mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int PHT_ENTRIES = 1 << PHT_BITS;
    localparam int RAS_CW      = $clog2(RAS_DEPTH) + 1;

    logic [1:0]           r_pht [PHT_ENTRIES];
    logic [HIST_BITS-1:0] r_ghr;
    logic [CNT_W-1:0]     r_branch_cnt;
    logic [CNT_W-1:0]     r_mispred_cnt;

    logic [PHT_BITS-1:0]  w_hist;
    logic [PHT_BITS-1:0]  w_f_idx;
    logic [PHT_BITS-1:0]  w_e_idx;
    logic                 w_train;
    logic                 w_ras_push;
    logic                 w_ras_pop;
    logic                 w_ras_empty;
    logic [AW-1:0]        w_ras_top;
    logic [RAS_CW-1:0]    w_ras_count;
    pred_src_e            w_src;
    logic [1:0]           w_mis_inc;
    logic [CNT_W:0]       w_mis_sum;
    logic                 w_unused;

    // Fetch and execute see the same GHR in a given cycle; execute uses the pre-shift value.
    assign w_hist  = (MODE == 1) ? PHT_BITS'(r_ghr) : '0;
    assign w_f_idx = f_pc[PHT_BITS-1:0] ^ w_hist;
    assign w_e_idx = e_pc[PHT_BITS-1:0] ^ w_hist;

    assign w_train     = e_valid && e_icode == ICODE_JXX && e_ifun != IFUN_JMP;
    assign w_ras_empty = (w_ras_count == '0);
    assign w_unused    = ^{f_pc[AW-1:PHT_BITS], e_pc[AW-1:PHT_BITS]};

    always_comb begin
        w_src      = PRED_SEQ;
        pred_taken = 1'b0;
        ras_miss   = 1'b0;
        w_ras_push = 1'b0;
        w_ras_pop  = 1'b0;
        if (f_valid) begin
            case (f_icode)
                ICODE_JXX: begin
                    if (f_ifun == IFUN_JMP || r_pht[w_f_idx][1]) begin
                        w_src      = PRED_TARGET;
                        pred_taken = 1'b1;
                    end
                end
                ICODE_CALL: begin
                    w_src      = PRED_TARGET;
                    w_ras_push = ~f_stall;
                end
                ICODE_RET: begin
                    if (!w_ras_empty) begin
                        w_src      = PRED_RAS;
                        pred_taken = 1'b1;
                        w_ras_pop  = ~f_stall;
                    end else begin
                        ras_miss = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (w_src)
            PRED_TARGET: pred_pc = f_valC;
            PRED_RAS:    pred_pc = w_ras_top;
            default:     pred_pc = f_valP;
        endcase
    end

    y86_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_ras_push),
        .i_pop   (w_ras_pop),
        .i_data  (f_valP),
        .o_top   (w_ras_top),
        .o_count (w_ras_count)
    );

    // Fetch reads r_pht combinationally, so a same-cycle write is seen only next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                r_pht[i] <= CTR_WT;
            end
        end else if (w_train) begin
            r_pht[w_e_idx] <= ctr_next(r_pht[w_e_idx], e_Cnd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (MODE == 1 && w_train) begin
            r_ghr <= {r_ghr[HIST_BITS-2:0], e_Cnd};
        end
    end

    assign e_mispredict     = w_train && (e_Cnd != e_pred_taken);
    assign e_redirect_pc    = e_Cnd ? e_valC : e_valP;
    assign m_ret_mispredict = m_ret_valid && (m_ret_pred != m_valM);

    // Both mispredict sources may fire together; the extra sum bit detects saturation.
    assign w_mis_inc = {1'b0, e_mispredict} + {1'b0, m_ret_mispredict};
    assign w_mis_sum = {1'b0, r_mispred_cnt} + (CNT_W + 1)'(w_mis_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_train && r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            r_mispred_cnt <= w_mis_sum[CNT_W] ? '1 : w_mis_sum[CNT_W-1:0];
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_y86_branch_predictor.sv
// Directed bench for y86_branch_predictor: bimodal instance for most checks, gshare instance for the T/N pattern.
module tb_y86_branch_predictor;
    import y86_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        f_valid, f_stall;
    logic [63:0] f_pc, f_valC, f_valP;
    logic [3:0]  f_icode, f_ifun;
    logic        e_valid, e_Cnd, e_pred_taken;
    logic [3:0]  e_icode, e_ifun;
    logic [63:0] e_pc, e_valC, e_valP;
    logic        m_ret_valid;
    logic [63:0] m_ret_pred, m_valM;

    logic [63:0] pred_pc_b, pred_pc_g, redir_b, redir_g;
    logic        taken_b, taken_g, miss_b, miss_g;
    logic        emis_b, emis_g, mmis_b, mmis_g;
    logic [31:0] brc_b, brc_g, misc_b, misc_g;

    int n_checks = 0;
    int n_errors = 0;

    y86_branch_predictor #(.MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_stall(f_stall), .f_pc(f_pc),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
        .pred_pc(pred_pc_b), .pred_taken(taken_b), .ras_miss(miss_b),
        .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun), .e_pc(e_pc),
        .e_valC(e_valC), .e_valP(e_valP), .e_Cnd(e_Cnd), .e_pred_taken(e_pred_taken),
        .e_mispredict(emis_b), .e_redirect_pc(redir_b),
        .m_ret_valid(m_ret_valid), .m_ret_pred(m_ret_pred), .m_valM(m_valM),
        .m_ret_mispredict(mmis_b), .branch_cnt(brc_b), .mispred_cnt(misc_b)
    );

    y86_branch_predictor #(.MODE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_stall(f_stall), .f_pc(f_pc),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
        .pred_pc(pred_pc_g), .pred_taken(taken_g), .ras_miss(miss_g),
        .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun), .e_pc(e_pc),
        .e_valC(e_valC), .e_valP(e_valP), .e_Cnd(e_Cnd), .e_pred_taken(e_pred_taken),
        .e_mispredict(emis_g), .e_redirect_pc(redir_g),
        .m_ret_valid(m_ret_valid), .m_ret_pred(m_ret_pred), .m_valM(m_valM),
        .m_ret_mispredict(mmis_g), .branch_cnt(brc_g), .mispred_cnt(misc_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        f_valid = 0; f_stall = 0; f_pc = '0; f_icode = '0; f_ifun = '0; f_valC = '0; f_valP = '0;
        e_valid = 0; e_icode = '0; e_ifun = '0; e_pc = '0; e_valC = '0; e_valP = '0;
        e_Cnd = 0; e_pred_taken = 0;
        m_ret_valid = 0; m_ret_pred = '0; m_valM = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_fetch(input logic [63:0] pc, input logic [3:0] ic, input logic [3:0] fn,
                             input logic [63:0] vc, input logic [63:0] vp);
        f_valid = 1; f_pc = pc; f_icode = ic; f_ifun = fn; f_valC = vc; f_valP = vp;
    endtask

    task automatic set_exec(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] pc,
                            input logic [63:0] vc, input logic [63:0] vp, input logic cnd, input logic pt);
        e_valid = 1; e_icode = ic; e_ifun = fn; e_pc = pc; e_valC = vc; e_valP = vp;
        e_Cnd = cnd; e_pred_taken = pt;
    endtask

    task automatic train(input logic [63:0] pc, input logic cnd);
        set_exec(ICODE_JXX, 4'h1, pc, 64'h100, 64'h4A, cnd, cnd);
        tick();
    endtask

    task automatic fetch_jxx_40();
        set_fetch(64'h40, ICODE_JXX, 4'h1, 64'h100, 64'h4A);
        #1;
    endtask

    int          bad_b, bad_g;
    logic        outcome;
    logic [63:0] exp_pc;

    initial begin
        idle();
        rst_n = 0;
        #2;
        f_valP = 64'h99;
        #1;
        check("rst_pred_pc", pred_pc_b, 64'h99);
        check("rst_pred_taken", taken_b, 0);
        check("rst_ras_miss", miss_b, 0);
        check("rst_branch_cnt", brc_b, 0);
        check("rst_mispred_cnt", misc_b, 0);
        #9 rst_n = 1;
        tick();

        // Weakly-taken start predicts the jXX taken.
        fetch_jxx_40();
        check("t1_taken", taken_b, 1);
        check("t1_pred_pc", pred_pc_b, 64'h100);
        check("t1_ras_miss", miss_b, 0);
        tick();

        // Train 0x40 down to strongly not-taken, then back up.
        set_exec(ICODE_JXX, 4'h1, 64'h40, 64'h100, 64'h4A, 0, 0);
        #1;
        check("t2_no_mispredict", emis_b, 0);
        tick();
        train(64'h40, 0);
        fetch_jxx_40();
        check("t2_pred_pc_nt", pred_pc_b, 64'h4A);
        check("t2_taken_nt", taken_b, 0);
        tick();
        train(64'h40, 0);
        check("t2_branch_cnt", brc_b, 3);
        train(64'h40, 1);
        fetch_jxx_40();
        check("t2_floor_sticks", taken_b, 0);
        set_exec(ICODE_JXX, 4'h1, 64'h40, 64'h100, 64'h4A, 1, 1);
        #1;
        check("t2_rbw_old_value", taken_b, 0);
        tick();
        fetch_jxx_40();
        check("t2_rbw_new_value", taken_b, 1);
        tick();
        train(64'h40, 1);
        train(64'h40, 1);
        train(64'h40, 0);
        fetch_jxx_40();
        check("t2_ceiling_sticks", taken_b, 1);
        check("t2_ceiling_pc", pred_pc_b, 64'h100);
        check("t2_branch_cnt8", brc_b, 8);
        check("t2_mispred_cnt0", misc_b, 0);
        tick();

        // Execute-side resolution and redirect.
        set_exec(ICODE_JXX, 4'h1, 64'h60, 64'h300, 64'h55, 0, 1);
        #1;
        check("t3_mispredict", emis_b, 1);
        check("t3_redirect_fall", redir_b, 64'h55);
        tick();
        check("t3_mispred_cnt", misc_b, 1);
        check("t3_branch_cnt", brc_b, 9);
        set_exec(ICODE_JXX, 4'h1, 64'h60, 64'h300, 64'h55, 1, 1);
        #1;
        check("t3_correct", emis_b, 0);
        check("t3_redirect_tgt", redir_b, 64'h300);
        tick();
        set_exec(ICODE_JXX, IFUN_JMP, 64'h60, 64'h300, 64'h55, 1, 0);
        #1;
        check("t3_jmp_no_mispredict", emis_b, 0);
        tick();
        set_exec(ICODE_JXX, 4'h1, 64'h60, 64'h300, 64'h55, 0, 1);
        e_valid = 0;
        #1;
        check("t3_invalid_no_mispredict", emis_b, 0);
        tick();
        check("t3_branch_cnt_hold", brc_b, 10);
        check("t3_mispred_cnt_hold", misc_b, 1);

        // Call/ret through the RAS.
        set_fetch(64'h8, ICODE_CALL, 4'h0, 64'h200, 64'h10);
        #1;
        check("t4_call_pc", pred_pc_b, 64'h200);
        tick();
        set_fetch(64'h18, ICODE_CALL, 4'h0, 64'h200, 64'h20);
        tick();
        set_fetch(64'h200, ICODE_RET, 4'h0, 64'h0, 64'h201);
        #1;
        check("t4_ret1_pc", pred_pc_b, 64'h20);
        check("t4_ret1_taken", taken_b, 1);
        check("t4_ret1_miss", miss_b, 0);
        tick();
        set_fetch(64'h200, ICODE_RET, 4'h0, 64'h0, 64'h201);
        #1;
        check("t4_ret2_pc", pred_pc_b, 64'h10);
        tick();
        set_fetch(64'h200, ICODE_RET, 4'h0, 64'h0, 64'h77);
        #1;
        check("t4_ret3_miss", miss_b, 1);
        check("t4_ret3_pc", pred_pc_b, 64'h77);
        check("t4_ret3_taken", taken_b, 0);
        tick();
        set_fetch(64'h200, ICODE_RET, 4'h0, 64'h0, 64'h77);
        #1;
        check("t4_ret4_still_empty", miss_b, 1);
        m_ret_valid = 1; m_ret_pred = 64'h20; m_valM = 64'h20;
        #1;
        check("t4_mret_match", mmis_b, 0);
        m_valM = 64'h24;
        #1;
        check("t4_mret_mismatch", mmis_b, 1);
        tick();
        check("t4_mispred_cnt", misc_b, 2);
        set_exec(ICODE_JXX, 4'h1, 64'h60, 64'h300, 64'h55, 0, 1);
        m_ret_valid = 1; m_ret_pred = 64'h20; m_valM = 64'h30;
        tick();
        check("t4_mispred_cnt_dual", misc_b, 4);
        check("t4_branch_cnt", brc_b, 11);

        // Stalled call must not push; then overflow the stack.
        f_stall = 1;
        set_fetch(64'h8, ICODE_CALL, 4'h0, 64'h500, 64'hAA);
        #1;
        check("t5_stall_call_pc", pred_pc_b, 64'h500);
        tick();
        set_fetch(64'h500, ICODE_RET, 4'h0, 64'h0, 64'h77);
        #1;
        check("t5_stall_no_push", miss_b, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_fetch(64'h2000 + 64'(i * 4), ICODE_CALL, 4'h0, 64'h500, 64'h1000 + 64'(i * 8));
            tick();
        end
        f_stall = 1;
        set_fetch(64'h500, ICODE_RET, 4'h0, 64'h0, 64'h77);
        #1;
        check("t5_stalled_ret_top", pred_pc_b, 64'h1048);
        tick();
        for (int k = 0; k < 8; k++) begin
            exp_pc = 64'h1000 + 64'((9 - k) * 8);
            set_fetch(64'h500, ICODE_RET, 4'h0, 64'h0, 64'h77);
            #1;
            check($sformatf("t5_ret%0d_pc", k), pred_pc_b, exp_pc);
            check($sformatf("t5_ret%0d_taken", k), taken_b, 1);
            tick();
        end
        set_fetch(64'h500, ICODE_RET, 4'h0, 64'h0, 64'h77);
        #1;
        check("t5_drained_miss", miss_b, 1);
        check("t5_drained_pc", pred_pc_b, 64'h77);
        tick();

        // Reset mid-operation clears everything immediately.
        set_fetch(64'h8, ICODE_CALL, 4'h0, 64'h500, 64'hBB);
        tick();
        set_fetch(64'h500, ICODE_RET, 4'h0, 64'h0, 64'h77);
        #1;
        check("t6_pre_rst_ras", pred_pc_b, 64'hBB);
        rst_n = 0;
        #1;
        check("t6_rst_ras_miss", miss_b, 1);
        check("t6_rst_branch_cnt", brc_b, 0);
        check("t6_rst_mispred_cnt", misc_b, 0);
        #1 rst_n = 1;
        tick();

        // Alternating T/N on one PC: gshare learns it, bimodal cannot.
        bad_b = 0;
        bad_g = 0;
        for (int i = 0; i < 20; i++) begin
            outcome = (i % 2 == 0);
            set_fetch(64'h80, ICODE_JXX, 4'h1, 64'h300, 64'h84);
            set_exec(ICODE_JXX, 4'h1, 64'h80, 64'h300, 64'h84, outcome, 0);
            #1;
            if (i >= 10) begin
                if (taken_b != outcome) bad_b++;
                if (taken_g != outcome) bad_g++;
            end
            tick();
        end
        check("t6_bimodal_mispredicts", 64'(bad_b), 5);
        check("t6_gshare_mispredicts", 64'(bad_g), 0);
        check("t6_gshare_branch_cnt", brc_g, 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
